// File: rtl/zero_run_tracker.sv
// zero_run_tracker: flags all-zero words and tracks zero-run lengths behind a registered two-entry (output + skid) buffer
module zero_run_tracker #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_zero,
  output logic [CNT_W-1:0] out_run,
  output logic             out_run_end
);
  logic [CNT_W-1:0] r_run;
  logic [CNT_W+1:0] r_o, r_s;
  logic             r_o_v, r_s_v, r_rdy;
  logic             w_acc, w_zero;
  logic [CNT_W-1:0] w_base, w_inc;
  logic [CNT_W+1:0] w_rec;
  always_comb begin
    w_acc  = in_valid && r_rdy;
    w_zero = ~|in_data;
    w_base = clear ? '0 : r_run;
    w_inc  = &w_base ? w_base : w_base + 1'b1;
    w_rec  = {w_zero, w_zero ? w_inc : w_base, !w_zero && |w_base};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= '0;
      r_o   <= '0;
      r_s   <= '0;
      r_o_v <= 1'b0;
      r_s_v <= 1'b0;
      r_rdy <= 1'b1;
    end else begin
      r_run <= w_acc ? (w_zero ? w_inc : '0) : w_base;
      if (r_o_v && !out_ready) begin
        if (w_acc) begin
          r_s   <= w_rec;
          r_s_v <= 1'b1;
          r_rdy <= 1'b0;
        end
      end else if (r_s_v) begin
        r_o   <= r_s;
        r_o_v <= 1'b1;
        r_s_v <= 1'b0;
        r_rdy <= 1'b1;
      end else begin
        r_o_v <= w_acc;
        if (w_acc) r_o <= w_rec;
      end
    end
  end
  assign in_ready    = r_rdy;
  assign out_valid   = r_o_v;
  assign out_zero    = r_o[CNT_W+1];
  assign out_run     = r_o[CNT_W:1];
  assign out_run_end = r_o[0];
endmodule

// File: tb/tb_zero_run_tracker.sv
// tb_zero_run_tracker: directed self-checking bench for zero_run_tracker
module tb_zero_run_tracker;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_zero;
  logic [7:0] out_run;
  logic       out_run_end;
  int checks = 0;
  int failures = 0;
  zero_run_tracker #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_zero(out_zero), .out_run(out_run), .out_run_end(out_run_end)
  );
  always #5 clk = ~clk;
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_zero, out_run, out_run_end} !== 11'd0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%0b z=%0b run=%0d end=%0b want all 0", out_valid, out_zero, out_run, out_run_end);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %0b want 1", in_ready);
    end
    rst_n = 1'b1;
  endtask
  task automatic test_basic();
    logic [3:0] d [6];
    logic [9:0] e [6];
    d = '{4'd0, 4'd0, 4'd0, 4'd5, 4'd0, 4'd3};
    e = '{{1'b1, 8'd1, 1'b0}, {1'b1, 8'd2, 1'b0}, {1'b1, 8'd3, 1'b0},
          {1'b0, 8'd3, 1'b1}, {1'b1, 8'd1, 1'b0}, {1'b0, 8'd1, 1'b1}};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data = d[i];
      step();
      checks++;
      if ({out_valid, out_zero, out_run, out_run_end} !== {1'b1, e[i]}) begin
        failures++;
        $display("FAIL basic_rec%0d: got v=%0b z=%0b run=%0d end=%0b want v=1 z=%0b run=%0d end=%0b",
                 i, out_valid, out_zero, out_run, out_run_end, e[i][9], e[i][8:1], e[i][0]);
      end
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL basic_ready%0d: got %0b want 1", i, in_ready);
      end
    end
    in_valid = 1'b0;
  endtask
  task automatic test_saturation();
    int exp_run;
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1;
      in_data = 4'd0;
      step();
      exp_run = (i + 1 > 255) ? 255 : i + 1;
      checks++;
      if (out_valid !== 1'b1 || out_zero !== 1'b1 || out_run !== exp_run[7:0] || out_run_end !== 1'b0) begin
        failures++;
        $display("FAIL sat_zero%0d: got v=%0b z=%0b run=%0d end=%0b want v=1 z=1 run=%0d end=0",
                 i, out_valid, out_zero, out_run, out_run_end, exp_run);
      end
    end
    in_data = 4'd1;
    step();
    checks++;
    if ({out_valid, out_zero, out_run, out_run_end} !== {1'b1, 1'b0, 8'd255, 1'b1}) begin
      failures++;
      $display("FAIL sat_end: got v=%0b z=%0b run=%0d end=%0b want v=1 z=0 run=255 end=1", out_valid, out_zero, out_run, out_run_end);
    end
    in_valid = 1'b0;
    step();
  endtask
  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 4'd0;
    step();
    checks++;
    if ({out_valid, out_zero, out_run, out_run_end, in_ready} !== {1'b1, 1'b1, 8'd1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL bp_a_in_o: got v=%0b z=%0b run=%0d end=%0b rdy=%0b want v=1 z=1 run=1 end=0 rdy=1", out_valid, out_zero, out_run, out_run_end, in_ready);
    end
    step();
    checks++;
    if ({out_valid, out_zero, out_run, out_run_end, in_ready} !== {1'b1, 1'b1, 8'd1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL bp_b_in_s: got v=%0b z=%0b run=%0d end=%0b rdy=%0b want v=1 z=1 run=1 end=0 rdy=0", out_valid, out_zero, out_run, out_run_end, in_ready);
    end
    in_data = 4'd7;
    step();
    checks++;
    if ({out_valid, out_zero, out_run, out_run_end, in_ready} !== {1'b1, 1'b1, 8'd1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL bp_c_blocked: got v=%0b z=%0b run=%0d end=%0b rdy=%0b want v=1 z=1 run=1 end=0 rdy=0", out_valid, out_zero, out_run, out_run_end, in_ready);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if ({out_valid, out_zero, out_run, out_run_end, in_ready} !== {1'b1, 1'b1, 8'd2, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL bp_release_b: got v=%0b z=%0b run=%0d end=%0b rdy=%0b want v=1 z=1 run=2 end=0 rdy=1", out_valid, out_zero, out_run, out_run_end, in_ready);
    end
    step();
    checks++;
    if ({out_valid, out_zero, out_run, out_run_end} !== {1'b1, 1'b0, 8'd2, 1'b1}) begin
      failures++;
      $display("FAIL bp_c_rec: got v=%0b z=%0b run=%0d end=%0b want v=1 z=0 run=2 end=1", out_valid, out_zero, out_run, out_run_end);
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_no_dup: got out_valid=%0b want 0", out_valid);
    end
  endtask
  task automatic test_clear();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 4'd0;
    repeat (4) step();
    checks++;
    if ({out_valid, out_zero, out_run, out_run_end} !== {1'b1, 1'b1, 8'd4, 1'b0}) begin
      failures++;
      $display("FAIL clear_prerun: got v=%0b z=%0b run=%0d end=%0b want v=1 z=1 run=4 end=0", out_valid, out_zero, out_run, out_run_end);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if ({out_valid, out_zero, out_run, out_run_end} !== {1'b1, 1'b1, 8'd1, 1'b0}) begin
      failures++;
      $display("FAIL clear_coincident: got v=%0b z=%0b run=%0d end=%0b want v=1 z=1 run=1 end=0", out_valid, out_zero, out_run, out_run_end);
    end
    step();
    checks++;
    if ({out_valid, out_zero, out_run, out_run_end} !== {1'b1, 1'b1, 8'd2, 1'b0}) begin
      failures++;
      $display("FAIL clear_next: got v=%0b z=%0b run=%0d end=%0b want v=1 z=1 run=2 end=0", out_valid, out_zero, out_run, out_run_end);
    end
    in_data = 4'd5;
    step();
    checks++;
    if ({out_valid, out_zero, out_run, out_run_end} !== {1'b1, 1'b0, 8'd2, 1'b1}) begin
      failures++;
      $display("FAIL clear_term: got v=%0b z=%0b run=%0d end=%0b want v=1 z=0 run=2 end=1", out_valid, out_zero, out_run, out_run_end);
    end
    in_valid = 1'b0;
  endtask
  task automatic test_nonzero();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 4'd9;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({out_valid, out_zero, out_run, out_run_end} !== {1'b1, 1'b0, 8'd0, 1'b0}) begin
        failures++;
        $display("FAIL nonzero%0d: got v=%0b z=%0b run=%0d end=%0b want v=1 z=0 run=0 end=0", i, out_valid, out_zero, out_run, out_run_end);
      end
    end
    in_valid = 1'b0;
    step();
  endtask
  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 4'd0;
    repeat (2) step();
    checks++;
    if ({out_valid, in_ready} !== 2'b10) begin
      failures++;
      $display("FAIL rstmid_full: got v=%0b rdy=%0b want v=1 rdy=0", out_valid, in_ready);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_zero, out_run, out_run_end, in_ready} !== {1'b0, 1'b0, 8'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL rstmid_async: got v=%0b z=%0b run=%0d end=%0b rdy=%0b want v=0 z=0 run=0 end=0 rdy=1", out_valid, out_zero, out_run, out_run_end, in_ready);
    end
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_zero, out_run, out_run_end} !== {1'b1, 1'b1, 8'd1, 1'b0}) begin
      failures++;
      $display("FAIL rstmid_first: got v=%0b z=%0b run=%0d end=%0b want v=1 z=1 run=1 end=0", out_valid, out_zero, out_run, out_run_end);
    end
    step();
  endtask
  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_clear();
    test_nonzero();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
